// File: rtl/hilo_div.sv
// hilo_div: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO write port. EX raises start_i and
// holds it until ready_o is high, then drops it for at least one cycle.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed DIV, 0 = DIVU (sampled with start_i)
//   opdata1_i     dividend (sampled with start_i)
//   opdata2_i     divisor  (sampled with start_i)
//   start_i       division request, held until ready_o
//   annul_i       abort an operation that has not yet finished
//   result_o      {remainder, quotient}, valid only while ready_o = 1
//   ready_o       result valid
module hilo_div #(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam int unsigned CntW = $clog2(DW + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DW);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [2*DW-1:0] result_q, result_d;
  logic            ready_q, ready_d;

  // Operand magnitudes; only negative in signed mode.
  logic          op1_neg, op2_neg;
  logic [DW-1:0] op1_mag, op2_mag;

  assign op1_neg = signed_div_i & opdata1_i[DW-1];
  assign op2_neg = signed_div_i & opdata2_i[DW-1];
  assign op1_mag = op1_neg ? (~opdata1_i + DW'(1)) : opdata1_i;
  assign op2_mag = op2_neg ? (~opdata2_i + DW'(1)) : opdata2_i;

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor
  // from the upper DW+1 bits. rem < divisor keeps the difference within DW bits.
  logic [DW:0] shifted, diff;

  assign shifted = {rem_q, quo_q[DW-1]};
  assign diff    = shifted - {1'b0, divisor_q};

  logic [DW-1:0] quo_fix, rem_fix;

  assign quo_fix = neg_quo_q ? (~quo_q + DW'(1)) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + DW'(1)) : rem_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFree;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFree: begin
        if (start_i && !annul_i) begin
          state_d = (opdata2_i == '0) ? StByZero : StOn;
        end
      end
      StByZero: state_d = annul_i ? StFree : StEnd;
      StOn: begin
        if (annul_i) begin
          state_d = StFree;
        end else if (cnt_q == CntLast) begin
          state_d = StEnd;
        end
      end
      StEnd: begin
        if (!start_i) begin
          state_d = StFree;
        end
      end
      default: state_d = StFree;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    unique case (state_q)
      StFree: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          quo_d     = op1_mag;
          rem_d     = '0;
          divisor_d = op2_mag;
          cnt_d     = '0;
          neg_quo_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
        end
      end
      StByZero: begin
        ready_d  = 1'b0;
        result_d = '0;
      end
      StOn: begin
        if (annul_i) begin
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q != CntLast) begin
          if (!diff[DW]) begin
            rem_d = diff[DW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b1};
          end else begin
            rem_d = shifted[DW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b0};
          end
          cnt_d = cnt_q + CntW'(1);
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end
      StEnd: begin
        // Divide-by-zero arrives here with ready low; it is raised one edge later.
        if (start_i) begin
          ready_d = 1'b1;
        end else begin
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_hilo_div.sv
// Directed testbench for hilo_div with hand-computed expected results.
module tb_hilo_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests = 0;
  int fails = 0;

  hilo_div #(.DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts a division; edge 0 is the first edge after start_i rises. Checks ready
  // is low after edge lat-1 and high with the expected result after edge lat.
  // scr_edge > 0 scrambles inputs after that edge; hold > 0 keeps start high for
  // that many extra edges in END with annul_i asserted.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat,
                         input int scr_edge, input int hold);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    for (int e = 1; e < lat; e++) begin
      tick();
      if (e == scr_edge) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~signed_div_i;
      end
    end
    check({tag, " ready_early"}, 64'(ready_o), 64'd0);
    tick();
    check({tag, " ready"}, 64'(ready_o), 64'd1);
    check({tag, " result"}, result_o, exp);
    for (int h = 0; h < hold; h++) begin
      annul_i = 1'b1;
      tick();
      check({tag, " hold_ready"}, 64'(ready_o), 64'd1);
      check({tag, " hold_result"}, result_o, exp);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    check({tag, " drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, " drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    logic seen;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    // 1: DIVU 100/7 = 14 r 2, END held with annul ignored.
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0, 2);

    // 2: signed results truncate toward zero, remainder follows dividend.
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 0, 0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0, 0);

    // 3: divide by zero and signed overflow.
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2, 0, 0);
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0, 0);

    // 4: inputs changed mid-operation are ignored.
    run_div("divu_scramble", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 5, 0);

    // 5: annul at edge 10 aborts; ready never rises; fresh start works.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    tick();
    for (int e = 1; e < 10; e++) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    check("annul_ready", 64'(ready_o), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | ready_o;
    end
    check("annul_never_ready", 64'(seen), 64'd0);
    run_div("divu_1000_3", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 33, 0, 0);

    // 6: reset mid-division, then blocked start in FREE, then reset in END.
    opdata1_i = 32'h12345678;
    opdata2_i = 32'h11;
    start_i   = 1'b1;
    tick();
    for (int e = 1; e < 20; e++) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    annul_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("free_annul_ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    run_div("divu_after_block", 1'b0, 32'h12345678, 32'h11, 64'h00000004_01122334, 33, 0, 0);

    start_i = 1'b1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    for (int i = 0; i < 34; i++) tick();
    check("end_ready", 64'(ready_o), 64'd1);
    rst = 1'b1;
    tick();
    check("rst_end_ready", 64'(ready_o), 64'd0);
    check("rst_end_result", result_o, 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_div.md
Name: hilo_div

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU; this is the producer side of the HI/LO register.
- Sits beside the EX stage. EX starts it and stalls the pipeline until ready_o is high.
- Its 64-bit result is written to HI (remainder) and LO (quotient) through the HI/LO write port.

Parameters:
- DW, 32, operand width. The result is 2*DW. Only 32 is required to be verified.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU. Sampled with start_i.
- opdata1_i  input  DW  dividend. Sampled with start_i.
- opdata2_i  input  DW  divisor. Sampled with start_i.
- start_i  input  1  request. Held high by EX until ready_o is seen.
- annul_i  input  1  abort (pipeline flush or exception).
- result_o  output  2*DW  {remainder[63:32], quotient[31:0]}. Valid only while ready_o = 1.
- ready_o  output  1  result valid.

Behaviour:
- Reset: rst is synchronous, active-high, on clk. It forces state to FREE, result_o to 0, ready_o to 0, and the iteration counter to 0. This applies from any state, including mid-division; the operation is lost.
- States: FREE, BYZERO, ON, END. result_o and ready_o are registered.
- FREE:
  - ready_o = 0 and result_o = 0.
  - On an edge with start_i = 1 and annul_i = 0, latch signed_div_i and the operands:
    - Signed mode: latch magnitudes (two's-complement negate of negative operands). Remember dividend sign and quotient sign (sign1 xor sign2).
    - Unsigned mode: latch the operands as-is.
  - If the divisor == 0, go to BYZERO. Otherwise go to ON with cnt = 0 and the partial remainder = 0.
  - annul_i = 1 blocks the start.
- ON:
  - One restoring iteration per edge. Shift {rem, quo} left by 1 and subtract the divisor from the upper DW+1 bits.
  - If the difference is non-negative, keep it and set the quotient LSB to 1. Otherwise restore and set the LSB to 0.
  - cnt increments on each iteration.
  - When cnt == 32, the next edge applies sign correction and goes to END. Quotient is negated if the quotient sign is set. Remainder is negated if the dividend was negative.
  - annul_i = 1 in ON: the next edge goes to FREE, ready_o stays 0, and the partial result is discarded.
  - Input changes during ON are ignored because the operands are latched.
- BYZERO: the next edge goes to END with result 0.
- END:
  - ready_o = 1 and result_o holds the result.
  - Stays in END while start_i = 1; annul_i is ignored in END.
  - On the first edge with start_i = 0, go to FREE. ready_o and result_o return to 0 on that edge.
- Latency, with edge 0 = the edge that samples start_i in FREE:
  - Normal division: ready_o is high after edge 33.
  - Divide by zero: ready_o is high after edge 2.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wrap, no trap).
- Signed results: quotient truncates toward zero. The remainder has the sign of the dividend.
- A start_i that is still high after leaving END (back-to-back DIV) is treated as a new request in FREE, as long as EX has dropped it for one cycle. EX is required to drop start_i for one cycle between operations.

Test Plan:
1. DIVU 100 / 7, start held -> ready_o rises after edge 33; result_o = 0x00000002_0000000E; lowering start_i returns ready_o = 0 and result_o = 0 on the next edge.
2. DIV 0xFFFFFFF9 (-7) / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD. DIV 7 / 0xFFFFFFFE -> result_o = 0x00000001_FFFFFFFD.
3. DIVU 5 / 0 -> ready_o after edge 2, result_o = 0. DIV 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000.
4. DIVU 0xFFFFFFFF / 1, with opdata1_i/opdata2_i changed to random values at edge 5 -> result_o = 0x00000000_FFFFFFFF.
5. Start DIVU 1000 / 3, assert annul_i for 1 cycle at edge 10 -> FREE, ready_o never rises. A fresh start then yields 0x00000001_0000014D after 33 edges.
6. Assert rst at edge 20 of a division -> outputs 0 next edge, state FREE. start_i with annul_i = 1 in FREE -> no state change.
